// File: rtl/dbus_ctrl_pkg.sv
// Shared types for the M-stage data-bus controller: address/data words,
// access size encoding and controller FSM states.
package dbus_ctrl_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA,
        HOLD,
        DRAIN
    } dctrl_state_t;

endpackage

// File: rtl/dbus_ctrl_align.sv
// Combinational byte-lane logic: misalignment detect, store strobe/shift,
// and load extract with sign/zero extension.
module mem_align
    import dbus_ctrl_pkg::*;
(
    input  addr_t       addr_i,
    input  msize_t      size_i,
    input  logic        write_i,
    input  logic        signed_i,
    input  word_t       wdata_i,
    input  word_t       rdata_i,
    output logic        addr_err_o,
    output logic [3:0]  strobe_o,
    output word_t       wdata_o,
    output word_t       rdata_o
);

    logic [4:0] shamt;
    logic [3:0] lanes;
    word_t      shifted;

    assign shamt   = {addr_i[1:0], 3'b000};
    assign shifted = rdata_i >> shamt;
    assign wdata_o = wdata_i << shamt;

    always_comb begin
        addr_err_o = 1'b0;
        lanes      = 4'hF;
        rdata_o    = shifted;
        case (size_i)
            MSIZE1: begin
                lanes   = 4'b0001 << addr_i[1:0];
                rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            MSIZE2: begin
                addr_err_o = addr_i[0];
                lanes      = 4'b0011 << {addr_i[1], 1'b0};
                rdata_o    = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                addr_err_o = |addr_i[1:0];
            end
        endcase
        strobe_o = write_i ? lanes : 4'b0000;
    end

endmodule

// File: rtl/dbus_ctrl.sv
// M-stage data-bus controller: issues valid/addr_ok/data_ok transactions,
// stalls the pipeline while waiting, and returns aligned load data to W.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  addr_t       req_addr,
    input  msize_t      req_size,
    input  logic        req_signed,
    input  word_t       req_wdata,
    input  logic        m_adv,
    input  logic        flush,
    output logic        stall,
    output logic        addr_err,
    output word_t       rdata,
    output logic        dreq_valid,
    output addr_t       dreq_addr,
    output msize_t      dreq_size,
    output logic [3:0]  dreq_strobe,
    output word_t       dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  word_t       dresp_data
);

    dctrl_state_t state_q, state_d;
    addr_t  addr_q;
    msize_t size_q;
    logic   write_q, signed_q;
    word_t  wdata_q, rdata_q;
    logic   addr_acc_q, addr_acc_d;

    logic   in_idle, mis, issue, bus_done, complete;
    addr_t  sel_addr;
    msize_t sel_size;
    logic   sel_write, sel_signed;
    word_t  sel_wdata, ext_data;

    // Fields come straight from M while idle, from the latches once issued.
    assign in_idle    = (state_q == IDLE);
    assign sel_addr   = in_idle ? req_addr   : addr_q;
    assign sel_size   = in_idle ? req_size   : size_q;
    assign sel_write  = in_idle ? req_write  : write_q;
    assign sel_signed = in_idle ? req_signed : signed_q;
    assign sel_wdata  = in_idle ? req_wdata  : wdata_q;

    mem_align u_align (
        .addr_i     (sel_addr),
        .size_i     (sel_size),
        .write_i    (sel_write),
        .signed_i   (sel_signed),
        .wdata_i    (sel_wdata),
        .rdata_i    (dresp_data),
        .addr_err_o (mis),
        .strobe_o   (dreq_strobe),
        .wdata_o    (dreq_data),
        .rdata_o    (ext_data)
    );

    assign dreq_addr = sel_addr;
    assign dreq_size = sel_size;
    assign issue     = in_idle & req_valid & ~mis & ~flush;
    assign bus_done  = dresp_addr_ok & dresp_data_ok;
    assign complete  = (issue & bus_done)
                     | (state_q == WAIT_ADDR & ~flush & bus_done)
                     | (state_q == WAIT_DATA & ~flush & dresp_data_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_acc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_acc_q <= addr_acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_acc_d = addr_acc_q;
        case (state_q)
            IDLE: begin
                addr_acc_d = 1'b0;
                if (issue && !bus_done)
                    state_d = dresp_addr_ok ? WAIT_DATA : WAIT_ADDR;
            end
            WAIT_ADDR: begin
                if (flush && !bus_done) begin
                    state_d    = DRAIN;
                    addr_acc_d = dresp_addr_ok;
                end else if (flush) begin
                    state_d = IDLE;
                end else if (dresp_addr_ok && !bus_done) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flush) begin
                    state_d    = dresp_data_ok ? IDLE : DRAIN;
                    addr_acc_d = 1'b1;
                end
            end
            HOLD: begin
                if (m_adv || flush) state_d = IDLE;
            end
            DRAIN: begin
                // The bus never aborts: finish the handshake, drop the data.
                if (dresp_addr_ok) addr_acc_d = 1'b1;
                if (dresp_data_ok && (addr_acc_q || dresp_addr_ok)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (complete) state_d = m_adv ? IDLE : HOLD;
    end

    always_comb begin
        dreq_valid = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                dreq_valid = issue;
                stall      = issue & ~bus_done;
            end
            WAIT_ADDR: begin
                dreq_valid = 1'b1;
                stall      = ~bus_done;
            end
            WAIT_DATA: stall = ~dresp_data_ok;
            DRAIN: begin
                dreq_valid = ~addr_acc_q;
                stall      = 1'b1;
            end
            default: ;
        endcase
        addr_err = in_idle & req_valid & mis;
        rdata    = (state_q == HOLD) ? rdata_q : ext_data;
        if (reset) begin
            dreq_valid = 1'b0;
            stall      = 1'b0;
            addr_err   = 1'b0;
            rdata      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= MSIZE1;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (in_idle) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if (complete && !m_adv) rdata_q <= ext_data;
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: scoreboard of expected load results,
// immediate assertions at every comparison point.
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed, m_adv, flush;
    addr_t       req_addr;
    msize_t      req_size;
    word_t       req_wdata;
    logic        stall, addr_err, dreq_valid;
    word_t       rdata, dreq_data, dresp_data;
    addr_t       dreq_addr;
    msize_t      dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;

    int    checks = 0;
    int    errors = 0;
    int    scnt;
    word_t exp_q[$];

    dbus_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_wdata     (req_wdata),
        .m_adv         (m_adv),
        .flush         (flush),
        .stall         (stall),
        .addr_err      (addr_err),
        .rdata         (rdata),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got %h want <scoreboard empty>", tag, rdata);
        end else begin
            chk(tag, rdata, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 0; req_write = 0; req_signed = 0; req_addr = '0;
        req_size = MSIZE4; req_wdata = '0; m_adv = 1; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
    endtask

    task automatic load(input addr_t a, input msize_t s, input logic sg);
        req_valid = 1; req_write = 0; req_addr = a; req_size = s; req_signed = sg;
    endtask

    initial begin
        idle_in();
        reset = 1;
        load(32'h8000_0002, MSIZE4, 1'b0);
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'hFFFF_FFFF;
        tick(); tick(); #2;
        chk("rst_valid", dreq_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_aerr", addr_err, 0);
        chk("rst_rdata", rdata, 0);
        tick(); reset = 0; idle_in(); #2;

        // zero-wait signed byte load
        tick(); load(32'h8000_0003, MSIZE1, 1'b1);
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h8012_3456;
        exp_q.push_back(32'hFFFF_FF80); #2;
        chk("zw_valid", dreq_valid, 1);
        chk("zw_strobe", dreq_strobe, 0);
        chk("zw_stall", stall, 0);
        chk_pop("zw_rdata");

        // zero-wait half store
        tick(); req_write = 1; req_addr = 32'h8000_0002; req_size = MSIZE2;
        req_signed = 0; req_wdata = 32'h0000_1234; #2;
        chk("st_strobe", dreq_strobe, 4'b1100);
        chk("st_data", dreq_data, 32'h1234_0000);
        chk("st_size", dreq_size, MSIZE2);
        chk("st_stall", stall, 0);

        // delayed handshake: addr_ok at +3, data_ok at +5
        tick(); load(32'h8000_0010, MSIZE4, 1'b0);
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
        exp_q.push_back(32'hCAFE_F00D); scnt = 0; #2;
        chk("dl_issue", dreq_valid, 1);
        if (stall) scnt++;
        for (int i = 1; i <= 2; i++) begin
            tick(); req_addr = 32'h1234_5678 ^ i; req_size = MSIZE1;
            req_write = 1; req_wdata = $urandom; #2;
            chk("dl_hold_addr", dreq_addr, 32'h8000_0010);
            chk("dl_hold_size", dreq_size, MSIZE4);
            chk("dl_hold_strb", dreq_strobe, 0);
            chk("dl_hold_vld", dreq_valid, 1);
            if (stall) scnt++;
        end
        tick(); dresp_addr_ok = 1; #2;
        chk("dl_aok_addr", dreq_addr, 32'h8000_0010);
        if (stall) scnt++;
        tick(); dresp_addr_ok = 0; #2;
        chk("dl_wd_vld", dreq_valid, 0);
        if (stall) scnt++;
        tick(); dresp_data_ok = 1; dresp_data = 32'hCAFE_F00D; #2;
        chk("dl_done_stall", stall, 0);
        chk_pop("dl_rdata");
        chk("dl_stall_cnt", scnt, 5);

        // unsigned half load completing into HOLD
        tick(); load(32'h8000_0022, MSIZE2, 1'b0);
        dresp_addr_ok = 1; dresp_data_ok = 0; dresp_data = '0;
        exp_q.push_back(32'h0000_BEEF); #2;
        chk("hd_issue_stall", stall, 1);
        tick(); dresp_addr_ok = 0; dresp_data_ok = 1; dresp_data = 32'hBEEF_0000; m_adv = 0; #2;
        chk("hd_done_stall", stall, 0);
        chk_pop("hd_rdata");
        for (int i = 0; i < 2; i++) begin
            tick(); dresp_data_ok = 0; dresp_data = 32'h5555_AAAA; m_adv = (i == 1); #2;
            chk("hd_stall", stall, 0);
            chk("hd_rdata_held", rdata, 32'h0000_BEEF);
            chk("hd_no_req", dreq_valid, 0);
        end
        tick(); idle_in(); #2;
        chk("hd_idle_vld", dreq_valid, 0);

        // flush in WAIT_DATA, then a new load waits for the old data_ok
        tick(); load(32'h8000_0040, MSIZE4, 1'b0); dresp_addr_ok = 1; #2;
        chk("fl_issue_stall", stall, 1);
        tick(); dresp_addr_ok = 0; flush = 1; #2;
        chk("fl_flush_stall", stall, 1);
        chk("fl_flush_vld", dreq_valid, 0);
        tick(); flush = 0; load(32'h8000_0050, MSIZE4, 1'b0); #2;
        chk("fl_drain_stall", stall, 1);
        chk("fl_drain_vld", dreq_valid, 0);
        tick(); dresp_data_ok = 1; dresp_data = 32'hDEAD_BEEF; #2;
        chk("fl_dok_stall", stall, 1);
        chk("fl_dok_vld", dreq_valid, 0);
        tick(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h1122_3344;
        exp_q.push_back(32'h1122_3344); #2;
        chk("fl_new_vld", dreq_valid, 1);
        chk("fl_new_addr", dreq_addr, 32'h8000_0050);
        chk("fl_new_stall", stall, 0);
        chk_pop("fl_new_rdata");

        // misaligned word and half
        tick(); idle_in(); load(32'h8000_0062, MSIZE4, 1'b0); #2;
        chk("mw_aerr", addr_err, 1);
        chk("mw_vld", dreq_valid, 0);
        chk("mw_stall", stall, 0);
        tick(); req_addr = 32'h8000_0061; req_size = MSIZE2; #2;
        chk("mh_aerr", addr_err, 1);
        chk("mh_vld", dreq_valid, 0);

        // data_ok coincident with flush in WAIT_DATA
        tick(); load(32'h8000_0070, MSIZE1, 1'b0); dresp_addr_ok = 1; #2;
        chk("fd_issue_stall", stall, 1);
        tick(); dresp_addr_ok = 0; dresp_data_ok = 1; flush = 1; #2;
        chk("fd_stall", stall, 0);
        tick(); flush = 0; load(32'h8000_0074, MSIZE2, 1'b1);
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h0000_8001;
        exp_q.push_back(32'hFFFF_8001); #2;
        chk("fd_new_addr", dreq_addr, 32'h8000_0074);
        chk("fd_new_stall", stall, 0);
        chk_pop("fd_new_rdata");

        // flush in WAIT_ADDR: request kept on the bus until accepted
        tick(); load(32'h8000_0080, MSIZE4, 1'b0);
        dresp_addr_ok = 0; dresp_data_ok = 0; #2;
        tick(); flush = 1; #2;
        chk("fa_vld", dreq_valid, 1);
        chk("fa_stall", stall, 1);
        tick(); flush = 0; req_valid = 0; dresp_addr_ok = 1; #2;
        chk("fa_drain_vld", dreq_valid, 1);
        chk("fa_drain_addr", dreq_addr, 32'h8000_0080);
        tick(); dresp_addr_ok = 0; dresp_data_ok = 1; #2;
        chk("fa_dok_vld", dreq_valid, 0);
        chk("fa_dok_stall", stall, 1);
        tick(); idle_in(); #2;
        chk("fa_idle_vld", dreq_valid, 0);
        chk("fa_idle_stall", stall, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
